parallel_serial_interface: RTL
==============================

PARALLEL_SERIAL_INTERFACE -- requirements
Module: parallel_serial_interface

Interface
REQ-001 The block SHALL have no parameters; element width is fixed at 16 bits and byte width at 8 bits.
REQ-002 clk  input  1  single clock; all logic SHALL be clocked on its rising edge.
REQ-003 rst  input  1  reset, synchronous and active-high.
REQ-004 start  input  1  request to capture and transmit one 3x3 matrix; sampled only in IDLE.
REQ-005 a_out, b_out, c_out, d_out, e_out, f_out, g_out, h_out, i_out  input  16 each  matrix elements in row-major order, a first.
REQ-006 serial_out  output  8  current byte on the serial link.
REQ-007 out_valid  output  1  high when serial_out holds a byte to be taken.
REQ-008 out_ready  input  1  sink accepts the byte when high together with out_valid.
REQ-009 busy  output  1  high from the capture cycle until the last byte is accepted.
REQ-010 done  output  1  one-cycle pulse after the final byte is accepted.

Function
REQ-011 The FSM SHALL have three states: IDLE, SEND, FINISH.
REQ-012 IDLE: when start=1, the block SHALL copy all nine inputs into internal registers on that edge, clear the byte counter to 0, and go to SEND.
REQ-013 Inputs SHALL NOT be sampled after capture; input changes during SEND SHALL NOT alter transmitted data.
REQ-014 SEND: out_valid SHALL be 1 and serial_out SHALL equal byte[counter], driven from registers only.
REQ-015 Byte order SHALL be element a..i; within each element, the high byte [15:8] first, then the low byte [7:0] (byte 0 = a[15:8], byte 17 = i[7:0]).
REQ-016 A transfer SHALL occur on each edge with out_valid=1 and out_ready=1; the counter then increments by 1.
REQ-017 While out_ready=0, serial_out and the counter SHALL hold; stall length SHALL be unbounded.
REQ-018 With out_ready held at 1, the block SHALL transfer 18 bytes on 18 consecutive edges, starting the edge after capture.
REQ-019 When byte 17 transfers, the block SHALL go to FINISH; the counter SHALL never exceed 17 or wrap.
REQ-020 FINISH: done=1, out_valid=0, busy=0 for exactly one cycle; then return to IDLE unconditionally.
REQ-021 start asserted in SEND or FINISH SHALL be ignored; start held high in IDLE after FINISH SHALL start a new frame (back-to-back frames separated by exactly one FINISH cycle).
REQ-022 busy SHALL be 1 in SEND only; out_valid SHALL be 0 in IDLE and FINISH.
REQ-023 serial_out SHALL be 8'h00 whenever out_valid=0.

Reset
REQ-024 With rst=1 on an edge, state SHALL become IDLE, the counter and all captured registers 0, and serial_out=8'h00, out_valid=0, busy=0, done=0.
REQ-025 rst SHALL take priority over start and over transfers; reset mid-frame SHALL abandon the frame with no done pulse.
REQ-026 The first start SHALL be honoured on the first edge with rst=0.

Verification
REQ-027 Full frame: a..i = AA55,1234,5678,9ABC,DEF0,1122,3344,5566,7788, start one cycle, out_ready=1 -> bytes AA,55,12,34,56,78,9A,BC,DE,F0,11,22,33,44,55,66,77,88 on 18 consecutive edges, then done one cycle.
REQ-028 Backpressure: same frame, out_ready=0 for 3 cycles at byte 5 and 5 cycles at byte 16 -> identical byte sequence, serial_out stable during stalls, done 8 cycles later than REQ-027.
REQ-029 Input change: alter all inputs to FFFF one cycle after start -> transmitted bytes still match the captured values.
REQ-030 Start ignored: pulse start at byte 9 -> no restart, 18 bytes, single done pulse.
REQ-031 Reset mid-frame: rst at byte 7 -> next cycle out_valid=0, serial_out=00, busy=0, no done; new start sends the full frame from byte 0.
REQ-032 Back-to-back: start held high, out_ready=1 -> two complete frames separated by one FINISH cycle with done=1.

Source files
------------

// File: rtl/parallel_serial_interface.sv
// Captures a 3x3 matrix of 16-bit elements on start and streams it out as
// 18 bytes (element a..i, high byte first) over a valid/ready byte link.
// A one-cycle FINISH state carries the done pulse before returning to IDLE.
module parallel_serial_interface (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [15:0] a_out,
    input  logic [15:0] b_out,
    input  logic [15:0] c_out,
    input  logic [15:0] d_out,
    input  logic [15:0] e_out,
    input  logic [15:0] f_out,
    input  logic [15:0] g_out,
    input  logic [15:0] h_out,
    input  logic [15:0] i_out,
    input  logic        out_ready,
    output logic [7:0]  serial_out,
    output logic        out_valid,
    output logic        busy,
    output logic        done
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SEND   = 2'd1,
        FINISH = 2'd2
    } state_t;

    // Index of the final byte of a frame (9 elements x 2 bytes - 1).
    localparam logic [4:0] LAST_BYTE = 5'd17;

    state_t      state_q, state_d;
    logic [4:0]  cnt_q, cnt_d;
    logic        capture;

    logic [15:0] elem_in  [0:8];
    logic [7:0]  byte_sel [0:17];

    assign elem_in[0] = a_out;
    assign elem_in[1] = b_out;
    assign elem_in[2] = c_out;
    assign elem_in[3] = d_out;
    assign elem_in[4] = e_out;
    assign elem_in[5] = f_out;
    assign elem_in[6] = g_out;
    assign elem_in[7] = h_out;
    assign elem_in[8] = i_out;

    // One capture register per element; the byte table is a fixed rewiring
    // of those registers, so serial_out never depends on live inputs.
    generate
        for (genvar gi = 0; gi < 9; gi++) begin : g_elem
            logic [15:0] elem_q;

            // Hold the element captured at frame start until the next capture.
            always_ff @(posedge clk) begin
                if (rst) begin
                    elem_q <= '0;
                end else if (capture) begin
                    elem_q <= elem_in[gi];
                end
            end

            assign byte_sel[2*gi]     = elem_q[15:8];
            assign byte_sel[2*gi + 1] = elem_q[7:0];
        end
    endgenerate

    // State and byte counter registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state logic and outputs; outputs decode from registered state only.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        capture    = 1'b0;
        serial_out = 8'h00;
        out_valid  = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    capture = 1'b1;
                    cnt_d   = '0;
                    state_d = SEND;
                end
            end
            SEND: begin
                out_valid  = 1'b1;
                busy       = 1'b1;
                serial_out = byte_sel[cnt_q];
                if (out_ready) begin
                    // Counter parks at the last index instead of wrapping.
                    if (cnt_q == LAST_BYTE) begin
                        state_d = FINISH;
                    end else begin
                        cnt_d = cnt_q + 5'd1;
                    end
                end
            end
            FINISH: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule
